// File: rtl/pattern_gen_pkg.sv
// Shared constants for the pattern generator: mode encodings, LFSR polynomial,
// command field layout and the single-step LFSR helper.
package pattern_gen_pkg;

   localparam logic [1:0] MODE_INCR  = 2'd0;
   localparam logic [1:0] MODE_CONST = 2'd1;
   localparam logic [1:0] MODE_WALK1 = 2'd2;
   localparam logic [1:0] MODE_LFSR  = 2'd3;

   localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

   localparam int CMD_WIDTH     = 96;
   localparam int CMD_SEED_LSB  = 0;
   localparam int CMD_SEED_W    = 32;
   localparam int CMD_COUNT_LSB = 32;
   localparam int CMD_COUNT_W   = 32;
   localparam int CMD_MODE_LSB  = 64;
   localparam int CMD_MODE_W    = 2;

   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0000_0000);
   endfunction

endpackage

// File: rtl/pattern_lfsr.sv
// 32-bit Galois LFSR. The register holds the word that follows the one
// currently presented, so its output is directly the next pattern word.
module pattern_lfsr
   import pattern_gen_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        load_i,
   input  logic [31:0] seed_i,
   input  logic        adv_i,
   output logic [31:0] state_o
);

   logic [31:0] state_q;
   logic [31:0] state_d;

   // Next-state selection: load wins over advance.
   always_comb begin
      state_d = state_q;
      if (load_i) begin
         state_d = lfsr_step(seed_i);
      end else if (adv_i) begin
         state_d = lfsr_step(state_q);
      end else begin
         state_d = state_q;
      end
   end

   // State register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= 32'h0000_0001;
      end else begin
         state_q <= state_d;
      end
   end

   assign state_o = state_q;

endmodule

// File: rtl/pattern_generator.sv
// Command-driven test-pattern source on a valid/ready stream.
// Define PATTERN_GEN_LFSR_EN to build the LFSR mode; otherwise mode 3 increments.
module pattern_generator
   import pattern_gen_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int LENGTH_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [95:0]           cmd_data,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   output logic [DATA_WIDTH-1:0] src_data,
   output logic                  src_valid,
   input  logic                  src_ready,
   output logic                  src_last,
   output logic                  busy,
   output logic                  done
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   localparam logic [LENGTH_WIDTH-1:0] REM_ONE = LENGTH_WIDTH'(1);
   localparam logic [LENGTH_WIDTH-1:0] REM_TWO = LENGTH_WIDTH'(2);
   localparam logic [DATA_WIDTH-1:0]   WALK_0  = DATA_WIDTH'(1);

   logic [0:0]              state_q, state_d;
   logic [1:0]              mode_q, mode_d;
   logic [31:0]             cur_q, cur_d;
   logic [DATA_WIDTH-1:0]   walk_q, walk_d;
   logic [LENGTH_WIDTH-1:0] rem_q, rem_d;
   logic [DATA_WIDTH-1:0]   data_q, data_d;
   logic                    valid_q, valid_d;
   logic                    last_q, last_d;
   logic                    done_q, done_d;

   logic [31:0]             cmd_seed_s;
   logic [LENGTH_WIDTH-1:0] cmd_count_s;
   logic [1:0]              cmd_mode_s;
   logic [1:0]              eff_mode_s;
   logic [31:0]             first32_s;
   logic [31:0]             next32_s;
   logic [31:0]             lfsr_state_s;
   logic [DATA_WIDTH-1:0]   walk_next_s;
   logic                    accept_s;
   logic                    hs_s;
   logic                    unused_s;

   function automatic logic [DATA_WIDTH-1:0] format_word(input logic [1:0] mode,
                                                         input logic [31:0] w,
                                                         input logic [DATA_WIDTH-1:0] walk);
      logic [DATA_WIDTH-1:0] ext;
      ext       = '0;
      ext[31:0] = w;
      case (mode)
         MODE_INCR:  format_word = ext;
         MODE_CONST: format_word = {(DATA_WIDTH/32){w}};
         MODE_WALK1: format_word = walk;
         MODE_LFSR:  format_word = {(DATA_WIDTH/32){w}};
         default:    format_word = ext;
      endcase
   endfunction

   assign cmd_seed_s  = cmd_data[CMD_SEED_LSB +: CMD_SEED_W];
   assign cmd_count_s = cmd_data[CMD_COUNT_LSB +: LENGTH_WIDTH];
   assign cmd_mode_s  = cmd_data[CMD_MODE_LSB +: CMD_MODE_W];
   assign unused_s    = ^cmd_data;

`ifdef PATTERN_GEN_LFSR_EN
   assign eff_mode_s = cmd_mode_s;

   pattern_lfsr u_lfsr (
      .clk_i   (clk),
      .rst_i   (reset),
      .load_i  (accept_s),
      .seed_i  (first32_s),
      .adv_i   (hs_s),
      .state_o (lfsr_state_s)
   );
`else
   assign eff_mode_s   = (cmd_mode_s == MODE_LFSR) ? MODE_INCR : cmd_mode_s;
   assign lfsr_state_s = 32'h0000_0000;
`endif

   assign accept_s    = (state_q == ST_IDLE) & cmd_valid;
   assign hs_s        = valid_q & src_ready;
   assign walk_next_s = {walk_q[DATA_WIDTH-2:0], walk_q[DATA_WIDTH-1]};
   // An all-zero LFSR seed would lock up, so it is promoted to 1.
   assign first32_s   = ((eff_mode_s == MODE_LFSR) && (cmd_seed_s == 32'h0000_0000))
                        ? 32'h0000_0001 : cmd_seed_s;

   // 32-bit lane value for the word after the current one.
   always_comb begin
      next32_s = cur_q + 32'd1;
      case (mode_q)
         MODE_INCR:  next32_s = cur_q + 32'd1;
         MODE_CONST: next32_s = cur_q;
         MODE_WALK1: next32_s = cur_q;
         MODE_LFSR:  next32_s = lfsr_state_s;
         default:    next32_s = cur_q + 32'd1;
      endcase
   end

   // FSM, counters and output-register next state.
   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      cur_d   = cur_q;
      walk_d  = walk_q;
      rem_d   = rem_q;
      data_d  = data_q;
      valid_d = valid_q;
      last_d  = last_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               mode_d = eff_mode_s;
               if (cmd_count_s == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = ST_RUN;
                  valid_d = 1'b1;
                  rem_d   = cmd_count_s;
                  last_d  = (cmd_count_s == REM_ONE);
                  cur_d   = first32_s;
                  walk_d  = WALK_0;
                  data_d  = format_word(eff_mode_s, first32_s, WALK_0);
               end
            end else begin
               done_d = 1'b0;
            end
         end
         ST_RUN: begin
            if (hs_s && last_q) begin
               state_d = ST_IDLE;
               valid_d = 1'b0;
               last_d  = 1'b0;
               data_d  = '0;
               done_d  = 1'b1;
            end else if (hs_s) begin
               rem_d  = rem_q - REM_ONE;
               last_d = (rem_q == REM_TWO);
               cur_d  = next32_s;
               walk_d = walk_next_s;
               data_d = format_word(mode_q, next32_s, walk_next_s);
            end else begin
               done_d = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            data_d  = '0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         mode_q  <= MODE_INCR;
         cur_q   <= 32'h0000_0000;
         walk_q  <= WALK_0;
         rem_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         cur_q   <= cur_d;
         walk_q  <= walk_d;
         rem_q   <= rem_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         done_q  <= done_d;
      end
   end

   assign cmd_ready = ~reset & (state_q == ST_IDLE);
   assign busy      = (state_q == ST_RUN);
   assign src_data  = data_q;
   assign src_valid = valid_q;
   assign src_last  = last_q;
   assign done      = done_q;

endmodule
